// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART receive path.
//   UART_DATA_W        payload width of one received character
//   UART_ENTRY_W       width of one buffered entry: {err, byte}
//   UART_CLK_HZ        system clock frequency on the target board
//   UART_BAUD          line rate
//   UART_CLKS_PER_BIT  clk cycles per bit period at UART_BAUD
//   uart_entry_t       packed buffered entry
//   make_entry()       packs an error tag and a byte into one entry
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_ENTRY_W      = UART_DATA_W + 1;
  localparam int UART_CLK_HZ       = 12_000_000;
  localparam int UART_BAUD         = 9600;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef logic [UART_ENTRY_W-1:0] uart_entry_t;

  // Error tag lives in the MSB so the byte stays right-aligned.
  function automatic uart_entry_t make_entry(input logic err,
                                             input logic [UART_DATA_W-1:0] data);
    return {err, data};
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH simple dual-port storage.
// Synchronous write, asynchronous read, no reset, so it maps onto
// distributed (LUT) RAM.
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  contents at raddr_i (combinational)
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the 8-bit UART receiver.
// Captures each byte on rxDone together with rxErr, holds it in a
// first-word-fall-through FIFO and presents it on a valid/ready port.
// Keeps a sticky overflow flag and a saturating error counter.
//   clk         in   system clock
//   reset       in   asynchronous active-high reset, clears all state
//   rxDone      in   one-cycle pulse, rxByte/rxErr valid
//   rxErr       in   framing error tag, qualified by rxDone
//   rxByte      in   received byte, qualified by rxDone
//   outValid    out  head entry available
//   outReady    in   consumer accepts head
//   outData     out  head byte
//   outErr      out  head error tag
//   level       out  occupancy 0..DEPTH
//   overflow    out  sticky: a byte was lost because the FIFO was full
//   errCount    out  saturating count of rxDone&&rxErr cycles
//   clearFlags  in   synchronous clear of overflow and errCount
//
// Handshake: a transfer happens on a rising clk edge where outValid and
// outReady are both 1. outValid depends only on registered state and
// never on outReady; outReady is ignored while outValid is 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit DROP_ERRORED = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [UART_DATA_W-1:0] rxByte,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [UART_DATA_W-1:0] outData,
  output logic                   outErr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             errCount,
  input  logic                   clearFlags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  uart_entry_t      head_q, head_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             full, empty;
  logic             push_req, push_acc, pop, err_event, ovf_event;
  logic [PTR_W-1:0] rd_next;
  uart_entry_t      wr_entry, next_entry;

  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign wr_entry  = make_entry(rxErr, rxByte);
  assign push_req  = rxDone && !(rxErr && DROP_ERRORED);
  assign pop       = !empty && outReady;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_acc  = push_req && (!full || pop);
  assign ovf_event = push_req && !push_acc;
  assign err_event = rxDone && rxErr;
  assign rd_next   = rd_ptr_q + PTR_W'(1);

  // The storage is read one slot ahead of the head so that the head
  // register can be refilled on the popping edge without a comb path
  // from storage to the outputs.
  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UART_ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_next),
    .rdata_o (next_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    head_d     = head_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end

    unique case ({push_acc, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Head register mirrors the entry at the read pointer. With one
    // entry left and a simultaneous push, the next head is the byte
    // being written this cycle, which the storage cannot show yet.
    // If the FIFO drains to empty the last value is held.
    if (pop) begin
      if (level_q == LVL_ONE) begin
        if (push_acc) begin
          head_d = wr_entry;
        end
      end else begin
        head_d = next_entry;
      end
    end else if (push_acc && empty) begin
      head_d = wr_entry;
    end

    // A new event in the clearing cycle survives the clear.
    if (clearFlags) begin
      overflow_d = ovf_event;
      err_cnt_d  = err_event ? 8'd1 : 8'd0;
    end else begin
      overflow_d = overflow_q | ovf_event;
      if (err_event && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign outValid = !empty;
  assign outData  = head_q[UART_DATA_W-1:0];
  assign outErr   = head_q[UART_ENTRY_W-1];
  assign level    = level_q;
  assign overflow = overflow_q;
  assign errCount = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo.
// dut keeps errored bytes (DROP_ERRORED=0); dut_drop discards them and
// has its own rxDone so it only sees the pulses aimed at it.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rxDone = 1'b0;
  logic          rxDone2 = 1'b0;
  logic          rxErr = 1'b0;
  logic [7:0]    rxByte = 8'h00;
  logic          outReady = 1'b0;
  logic          clearFlags = 1'b0;

  logic          outValid, outErr, overflow;
  logic [7:0]    outData, errCount;
  logic [LW-1:0] level;

  logic          d_outValid, d_outErr, d_overflow;
  logic [7:0]    d_outData, d_errCount;
  logic [LW-1:0] d_level;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERRORED(1'b0)) dut (
    .clk(clk), .reset(reset), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outErr(outErr),
    .level(level), .overflow(overflow), .errCount(errCount), .clearFlags(clearFlags)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERRORED(1'b1)) dut_drop (
    .clk(clk), .reset(reset), .rxDone(rxDone2), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(d_outValid), .outReady(outReady), .outData(d_outData), .outErr(d_outErr),
    .level(d_level), .overflow(d_overflow), .errCount(d_errCount), .clearFlags(clearFlags)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard monitor: the handshake is sampled mid-cycle, ahead of the
  // edge on which the transfer takes place.
  always @(negedge clk) begin
    if (!reset && outValid && outReady) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got err=%0b data=%02h, nothing expected", outErr, outData);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({outErr, outData} !== e) begin
          bad++;
          $display("FAIL pop_data: got err=%0b data=%02h, want err=%0b data=%02h",
                   outErr, outData, e[8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic e, input bit stored);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    if (stored) exp_q.push_back({e, b});
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
  endtask

  task automatic pulse_clear();
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    outReady = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    outReady = 1'b0;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_outValid", outValid, 0);
    check("rst_outData", outData, 0);
    check("rst_outErr", outErr, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_errCount", errCount, 0);
    reset = 1'b0;
    tick();

    // single byte, one-cycle visibility
    push(8'hB5, 1'b0, 1'b1);
    check("b5_valid", outValid, 1);
    check("b5_data", outData, 8'hB5);
    check("b5_err", outErr, 0);
    check("b5_level", level, 1);
    drain(4);
    check("b5_level_after", level, 0);
    check("b5_valid_after", outValid, 0);

    // qualifiers without rxDone are ignored
    rxByte = 8'hEE;
    rxErr  = 1'b1;
    tick();
    rxErr  = 1'b0;
    check("nodone_level", level, 0);
    check("nodone_errCount", errCount, 0);

    // fill to DEPTH, then one rejected byte
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b1);
    check("full_overflow_pre", overflow, 0);
    push(8'h10, 1'b0, 1'b0);
    check("full_level", level, DEPTH);
    check("full_overflow", overflow, 1);
    check("full_head", outData, 8'h00);
    pulse_clear();
    check("clear_overflow", overflow, 0);
    check("clear_level", level, DEPTH);

    // full, push and pop in the same cycle
    outReady = 1'b1;
    push(8'h55, 1'b0, 1'b1);
    outReady = 1'b0;
    check("fullpp_level", level, DEPTH);
    check("fullpp_overflow", overflow, 0);
    check("fullpp_head", outData, 8'h01);
    drain(40);
    check("fullpp_empty", level, 0);
    check("hold_last", outData, 8'h55);

    // errored byte: kept by dut, dropped by dut_drop, counted by both
    rxDone2 = 1'b1;
    push(8'hA5, 1'b1, 1'b1);
    rxDone2 = 1'b0;
    check("err_head_valid", outValid, 1);
    check("err_head_err", outErr, 1);
    check("err_head_data", outData, 8'hA5);
    check("err_count", errCount, 1);
    check("drop_level", d_level, 0);
    check("drop_valid", d_outValid, 0);
    check("drop_errCount", d_errCount, 1);
    drain(4);

    // saturation on the dropping instance
    pulse_clear();
    check("drop_cleared", d_errCount, 0);
    rxErr   = 1'b1;
    rxDone2 = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    rxDone2 = 1'b0;
    check("sat_errCount", d_errCount, 255);
    check("sat_level", d_level, 0);
    // clear together with a further error: the error wins
    rxDone2    = 1'b1;
    clearFlags = 1'b1;
    tick();
    rxDone2    = 1'b0;
    clearFlags = 1'b0;
    rxErr      = 1'b0;
    check("clear_vs_err", d_errCount, 1);

    // reset mid-stream
    pulse_clear();
    push(8'h11, 1'b0, 1'b1);
    push(8'h22, 1'b1, 1'b1);
    push(8'h33, 1'b0, 1'b1);
    push(8'h44, 1'b0, 1'b1);
    push(8'h66, 1'b0, 1'b1);
    check("mid_level", level, 5);
    check("mid_errCount", errCount, 1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("arst_valid", outValid, 0);
    check("arst_level", level, 0);
    check("arst_overflow", overflow, 0);
    check("arst_errCount", errCount, 0);
    rxByte = 8'h99;
    rxErr  = 1'b1;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    reset  = 1'b0;
    tick();
    check("inrst_level", level, 0);
    check("inrst_errCount", errCount, 0);
    push(8'h3C, 1'b0, 1'b1);
    check("post_head", outData, 8'h3C);
    drain(4);
    check("post_level", level, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
